key_debounce: RTL and testbench

- Per-key debouncer that feeds the LED-toggle top level with a clean one-cycle `key_cap` event.
- Samples a raw mechanical push-button, synchronises it into `clk_i`, and rejects bounce with a stability counter.
- Emits single-cycle press and release pulses plus a debounced level.

---
 rtl/key_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/key_debounce.sv | 126 ++++++++++++
 tb/tb_key_debounce.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding and 50 MHz timing defaults.
package key_pkg;

    localparam logic [1:0] KS_IDLE         = 2'd0;
    localparam logic [1:0] KS_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] KS_PRESSED      = 2'd2;
    localparam logic [1:0] KS_RELEASE_WAIT = 2'd3;

    // 20 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;
    localparam int DEF_KEY_ACTIVE_LOW  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchroniser, stability-counter FSM, registered press/release pulses and level.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_i,
    output logic key_press_o,
    output logic key_release_o,
    output logic key_level_o
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic          INACTIVE = (KEY_ACTIVE_LOW != 0);

    logic          w_key_sync;
    logic          r_act;
    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [CW-1:0] r_cnt;
    logic          w_repeat_fire;
    logic          w_press_next;
    logic          w_release_next;
    logic          w_level_next;
    logic          r_press;
    logic          r_release;
    logic          r_level;

    sync_2ff #(.RST_VAL(INACTIVE)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (key_i),
        .q_o     (w_key_sync)
    );

    // Polarity-normalised level, retimed once so the FSM sees a clean registered input.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_act <= 1'b0;
        else          r_act <= w_key_sync ^ INACTIVE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= KS_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            KS_IDLE:         if (r_act) w_state_next = KS_PRESS_WAIT;
            KS_PRESS_WAIT:   if (!r_act) w_state_next = KS_IDLE;
                             else if (r_cnt == DB_LAST) w_state_next = KS_PRESSED;
            KS_PRESSED:      if (!r_act) w_state_next = KS_RELEASE_WAIT;
            KS_RELEASE_WAIT: if (r_act) w_state_next = KS_PRESSED;
                             else if (r_cnt == DB_LAST) w_state_next = KS_IDLE;
            default:         w_state_next = KS_IDLE;
        endcase
    end

    // Counter runs only while a wait state persists; any exit or entry restarts it at zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if ((r_state == KS_PRESS_WAIT || r_state == KS_RELEASE_WAIT)
                     && w_state_next == r_state) begin
            r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_DELAY + REPEAT_PERIOD - 1);

    logic [CW-1:0] r_hold;

    // Hold counter folds back to REPEAT_DELAY after each periodic repeat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hold <= '0;
        end else if (r_state == KS_PRESSED && w_state_next == KS_PRESSED) begin
            r_hold <= (r_hold == RP_LAST) ? RD_LAST + 1'b1 : r_hold + 1'b1;
        end else begin
            r_hold <= '0;
        end
    end

    assign w_repeat_fire = (r_state == KS_PRESSED) && r_act
                           && (r_hold == RD_LAST || r_hold == RP_LAST);
`else
    assign w_repeat_fire = 1'b0;
`endif

    always_comb begin
        w_press_next   = ((r_state == KS_PRESS_WAIT) && r_act && (r_cnt == DB_LAST))
                         || w_repeat_fire;
        w_release_next = (r_state == KS_RELEASE_WAIT) && !r_act && (r_cnt == DB_LAST);
        w_level_next   = (w_state_next == KS_PRESSED) || (w_state_next == KS_RELEASE_WAIT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_level   <= 1'b0;
        end else begin
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_level   <= w_level_next;
        end
    end

    assign key_press_o   = r_press;
    assign key_release_o = r_release;
    assign key_level_o   = r_level;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed test-plan scenarios plus randomized key activity
// checked cycle by cycle against a run-length reference model (repeat rules apply under KEY_REPEAT_EN).
module tb_key_debounce;

    localparam int D  = 8;
    localparam int RD = 40;
    localparam int RP = 10;
    localparam int AL = 1;
`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n_i = 1'b0;
    logic key_i = 1'b1;
    logic key_press_o, key_release_o, key_level_o;

    key_debounce #(
        .DEBOUNCE_CYCLES (D),
        .KEY_ACTIVE_LOW  (AL),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .key_i         (key_i),
        .key_press_o   (key_press_o),
        .key_release_o (key_release_o),
        .key_level_o   (key_level_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic dly [3];
    logic m_level, prev_act;
    int   run, hold;
    logic exp_press, exp_release;

    // observed statistics
    int cyc = 0;
    int press_cnt, release_cnt, first_press, first_release;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) dly[i] = AL[0] ? 1'b1 : 1'b0;
        m_level = 1'b0; prev_act = 1'b0; run = 0; hold = 0;
        exp_press = 1'b0; exp_release = 1'b0;
    endtask

    // Input must differ from the accepted level on D+1 consecutive FSM samples to flip it.
    task automatic model_step();
        logic act, rep;
        exp_press = 1'b0; exp_release = 1'b0; rep = 1'b0;
        if (!rst_n_i) begin
            model_reset();
            return;
        end
        act = dly[2] ^ AL[0];
        dly[2] = dly[1]; dly[1] = dly[0]; dly[0] = key_i;
        if (act != m_level) begin
            run++;
            if (run == D + 1) begin
                m_level = act; run = 0; hold = 0;
                if (act) exp_press = 1'b1; else exp_release = 1'b1;
            end
        end else begin
            run = 0;
        end
        if (!exp_press) begin
            if (m_level && act && prev_act) begin
                hold++;
                rep = (hold == RD) || (hold > RD && (hold - RD) % RP == 0);
            end else begin
                hold = 0;
            end
        end
        if (REPEAT_ON && rep) exp_press = 1'b1;
        prev_act = act;
    endtask

    task automatic clear_stats();
        press_cnt = 0; release_cnt = 0; first_press = -1; first_release = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check("press", int'(key_press_o), int'(exp_press));
        check("release", int'(key_release_o), int'(exp_release));
        check("level", int'(key_level_o), int'(m_level));
        if (key_press_o) begin
            press_cnt++;
            if (first_press < 0) first_press = cyc;
        end
        if (key_release_o) begin
            release_cnt++;
            if (first_release < 0) first_release = cyc;
        end
    endtask

    task automatic drive(input logic v, input int n);
        key_i = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_pulse(input int n);
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check("rst_press", int'(key_press_o), 0);
        check("rst_release", int'(key_release_o), 0);
        check("rst_level", int'(key_level_o), 0);
        for (int i = 0; i < n; i++) tick();
        rst_n_i = 1'b1;
    endtask

    initial begin
        int t0, exp_rep;
        model_reset();
        clear_stats();
        @(negedge clk);
        reset_pulse(3);

        // clean press
        clear_stats(); t0 = cyc + 1;
        drive(1'b0, 30);
        check("clean_count", press_cnt, 1);
        check("clean_latency", first_press - t0, 11);
        check("clean_level", int'(key_level_o), 1);
        $display("[TB] clean press: presses=%0d latency=%0d", press_cnt, first_press - t0);

        // release
        clear_stats(); t0 = cyc + 1;
        drive(1'b1, 20);
        check("rel_count", release_cnt, 1);
        check("rel_latency", first_release - t0, 11);
        check("rel_nopress", press_cnt, 0);
        check("rel_level", int'(key_level_o), 0);
        $display("[TB] release: releases=%0d latency=%0d", release_cnt, first_release - t0);

        // bounce then stable press
        clear_stats();
        for (int i = 0; i < 18; i++) drive(((i / 3) % 2 == 0) ? 1'b0 : 1'b1, 1);
        check("bounce_quiet", press_cnt, 0);
        t0 = cyc + 1;
        drive(1'b0, 30);
        check("bounce_count", press_cnt, 1);
        check("bounce_latency", first_press - t0, 11);
        $display("[TB] bounce: presses=%0d latency=%0d", press_cnt, first_press - t0);

        // release bounce while pressed
        clear_stats();
        drive(1'b1, 4);
        drive(1'b0, 20);
        check("relb_release", release_cnt, 0);
        check("relb_press", press_cnt, 0);
        check("relb_level", int'(key_level_o), 1);
        $display("[TB] release bounce: presses=%0d releases=%0d", press_cnt, release_cnt);
        drive(1'b1, 20);

        // reset in PRESS_WAIT with counter at 5
        clear_stats();
        drive(1'b0, 9);
        reset_pulse(2);
        t0 = cyc + 1;
        drive(1'b0, 30);
        check("rstw_count", press_cnt, 1);
        check("rstw_latency", first_press - t0, 11);
        $display("[TB] reset mid-wait: presses=%0d latency=%0d", press_cnt, first_press - t0);
        drive(1'b1, 20);

        // randomized activity against the model
        clear_stats();
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 39) == 0) reset_pulse($urandom_range(1, 2));
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 14));
        end
        $display("[TB] random: presses=%0d releases=%0d", press_cnt, release_cnt);
        drive(1'b1, 20);

        // long hold
        clear_stats(); t0 = cyc + 1;
        drive(1'b0, 100);
        exp_rep = REPEAT_ON ? 6 : 1;
        check("hold_count", press_cnt, exp_rep);
        check("hold_first", first_press - t0, 11);
        clear_stats();
        drive(1'b1, 60);
        check("hold_rel_nopress", press_cnt, 0);
        check("hold_rel_count", release_cnt, 1);
        $display("[TB] long hold: presses=%0d then releases=%0d", exp_rep, release_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
